// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage with per-byte write enables; contents survive reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read is combinational so the responder can capture it on the commit edge.
    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with configurable wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_IDX_W = 30;

    dmem_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WORD_BYTES-1:0]   be_q, be_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic                    commit;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   bank_rdata;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // WAIT lasts WAIT_STATES+1 cycles; the access commits on the edge leaving it.
    assign commit   = (state_q == WAIT) && (cnt_q == '0);
    assign in_range = idx_q < ADDR_IDX_W'(DEPTH_WORDS);

    dmem_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (commit && we_q && in_range),
        .be    (be_q),
        .idx   (idx_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    we_d    = req_we;
                    idx_d   = req_addr[31:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                end
            end
            WAIT: begin
                if (commit) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = (!we_q && in_range) ? bank_rdata : '0;
                    resp_err_d   = !in_range;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = reset && (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench with a response scoreboard for dmem_responder.
module tb_dmem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    logic [31:0] resp_rdata;

    logic        f_req_valid = 1'b0, f_req_ready, f_req_we = 1'b0;
    logic [31:0] f_req_addr = '0, f_req_wdata = '0;
    logic [3:0]  f_req_be = '0;
    logic        f_resp_valid, f_resp_err;
    logic        f_resp_ready = 1'b1;
    logic [31:0] f_resp_rdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_fast (
        .clk(clk), .reset(reset_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_we(f_req_we), .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_be(f_req_be),
        .resp_valid(f_resp_valid), .resp_ready(f_resp_ready), .resp_rdata(f_resp_rdata),
        .resp_err(f_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop one expectation per response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_latency", 32'(rise_cyc - e.acc), 32'(WS + 1));
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk({name, "_ready_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic issue(input vec_t v);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_be = v.be;
        wait_ready("issue");
        @(posedge clk); #1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, acc: cyc});
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic fast_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
        int n = 0;
        int acc;
        @(posedge clk); #1;
        f_req_valid = 1'b1; f_req_we = we; f_req_addr = addr; f_req_wdata = wdata;
        f_req_be = 4'hF;
        while (n <= 50) begin
            @(negedge clk);
            if (f_req_ready) break;
            n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        f_req_valid = 1'b0; f_req_addr = $urandom;
        n = 0;
        while (n <= 50) begin
            @(negedge clk);
            if (f_resp_valid) break;
            n++;
        end
        chk("ws0_resp_valid", {31'd0, f_resp_valid}, 32'd1);
        chk("ws0_latency", 32'(cyc - acc), 32'd1);
        chk("ws0_rdata", f_resp_rdata, exp_rdata);
        chk("ws0_err", {31'd0, f_resp_err}, 32'd0);
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b1, 32'h24,       32'h01020304, 4'hF, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h24,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h24,       32'h0,        4'h0, 32'h01020304, 1'b0};
        tbl[12] = '{1'b1, 32'hFFC,      32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'hFFF,      32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        tbl[14] = '{1'b1, 32'h10,       32'h77000000, 4'h8, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h77ADBEEF, 1'b0};
        tbl[16] = '{1'b1, 32'h40,       32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        tbl[17] = '{1'b0, 32'hFFFFFFF0, 32'h0,        4'h0, 32'h0,        1'b1};

        // Reset state
        #12;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 18; i++) issue(tbl[i]);
        drain();

        // Back-pressure: response held, a waiting request is taken one cycle after handshake.
        resp_ready = 1'b0;
        issue('{1'b0, 32'h10, 32'h0, 4'h0, 32'h77ADBEEF, 1'b0});
        begin
            int n = 0;
            while (!resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'h0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_rdata", resp_rdata, 32'h77ADBEEF);
            chk("bp_resp_err", {31'd0, resp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_resp_dropped", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h11BB33DD, err: 1'b0, acc: cyc});
        req_valid = 1'b0;
        chk("bp_accepted", {31'd0, req_ready}, 32'd0);
        drain();

        // Reset during WAIT drops the uncommitted store.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h5; req_be = 4'hF;
        wait_ready("rst_store");
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue('{1'b0, 32'h40, 32'h0, 4'h0, 32'h0BADF00D, 1'b0});
        drain();

        // Zero wait states.
        fast_op(1'b1, 32'h8, 32'h13579BDF, 32'h0);
        fast_op(1'b0, 32'h8, 32'h0, 32'h13579BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
